switch_input_ctrl: RTL
======================

SWITCH_INPUT_CTRL -- requirements
Module: switch_input_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of switch inputs (legal 1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable samples required to accept a change (legal >=1).
REQ-003 SHALL have ports, clock and reset first: clk in 1 system clock; rst in 1 reset.
REQ-004 SHALL have ports: switches in WIDTH raw asynchronous switch levels; memAddress in 30 word address; writeData in 32 write bus; writeEnable in 1 write strobe; readEnable in 1 read strobe; readData out 32 registered read bus; irq out 1 interrupt request.
REQ-005 Reset: rst, asynchronous, active-high; clock: clk; all state rising-edge clk.

Function
REQ-006 SHALL pass each switch bit through a 2-flop synchroniser before any other use.
REQ-007 SHALL keep per-bit debounced state STABLE and per-bit counter of width clog2(DEBOUNCE_CYCLES)+1.
REQ-008 Counter SHALL clear on any edge where synchronised bit equals STABLE, else increment.
REQ-009 STABLE bit SHALL toggle on the DEBOUNCE_CYCLES-th consecutive edge with mismatch; counter clears on that same edge.
REQ-010 Switch change held steady SHALL appear in STABLE exactly 2+DEBOUNCE_CYCLES edges after first sampled; shorter pulses SHALL be rejected.
REQ-011 Register select SHALL be memAddress[1:0]; memAddress[29:2] ignored.
REQ-012 Reg 0 DATA, read-only: {zeros, STABLE}.
REQ-013 Reg 1 RISE, sticky: bit set on edge STABLE goes 0->1; write-1-to-clear via writeData[WIDTH-1:0].
REQ-014 Reg 2 FALL, sticky: bit set on edge STABLE goes 1->0; write-1-to-clear.
REQ-015 Simultaneous set and W1C clear of same bit SHALL leave bit set.
REQ-016 Writes to reg 0 SHALL be ignored; writes to reg 3 per REQ-023/024.
REQ-017 readData SHALL load selected register, zero-extended, on edge where readEnable=1; hold otherwise (latency 1).
REQ-018 Read and write same register same edge SHALL return pre-write value.
REQ-019 Bits [31:WIDTH] of every register SHALL read 0.

Reset
REQ-020 rst SHALL asynchronously clear synchronisers, STABLE, counters, RISE, FALL, MASK, readData and irq to 0.
REQ-021 rst mid-debounce SHALL discard partial count; switches already high after reset SHALL produce STABLE=1 and RISE set after 2+DEBOUNCE_CYCLES edges.
REQ-022 No register write or read SHALL take effect while rst is high.

Configuration
REQ-023 With SWITCH_IRQ_EN defined: reg 3 MASK read/write (low WIDTH bits); irq registered, = |((RISE|FALL) & MASK) evaluated on next state, so irq rises the edge a masked flag sets and falls the edge it clears.
REQ-024 Without SWITCH_IRQ_EN: MASK absent, reg 3 reads 0, writes ignored, irq tied 0; debounce and flags unchanged.

Verification
REQ-025 Reset then switches=16'h0001 held; count edges -> STABLE/DATA read 32'h00000001 first visible after edge 6 (2+4), RISE=32'h1.
REQ-026 switches bit 3 pulse high for 3 edges (DEBOUNCE_CYCLES=4) -> DATA stays 0, RISE stays 0.
REQ-027 RISE=0x1, write reg1 0x1 same edge bit 0 re-rises -> RISE remains 0x1; later write 0x1 alone -> RISE 0.
REQ-028 With SWITCH_IRQ_EN: MASK=0x4, bit 2 1->0 debounced -> FALL=0x4, irq=1; W1C FALL 0x4 -> irq=0 next edge; bit 1 change -> irq stays 0.
REQ-029 Without SWITCH_IRQ_EN: write 0xFFFF to reg3, read reg3 -> 0; irq constant 0.
REQ-030 Assert rst with counter at 3 of 4 -> all outputs 0 immediately, readData 0, no flag set after release until full 2+4 edges.

Source files
------------

// File: rtl/switch_input_ctrl.sv
// rtl/switch_input_ctrl.sv - debounced switch inputs with sticky RISE/FALL flags and register read port
// Optional SWITCH_IRQ_EN adds the MASK register (reg 3) and a registered irq output.
module switch_input_ctrl #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] switches,
    input  logic [29:0]      memAddress,
    input  logic [31:0]      writeData,
    input  logic             writeEnable,
    input  logic             readEnable,
    output logic [31:0]      readData,
    output logic             irq
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1, sync2;
    logic [WIDTH-1:0] stable, stable_next;
    logic [WIDTH-1:0] rise, rise_next, fall, fall_next;
    logic [WIDTH-1:0] clr_rise, clr_fall;
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];
    logic [1:0]       sel;
    logic [31:0]      reg_val;
    logic             unused_bits;

    assign sel         = memAddress[1:0];
    assign unused_bits = ^{memAddress[29:2], writeData};

    // A bit toggles on its DEBOUNCE_CYCLES-th consecutive mismatch; any match restarts the count.
    always_comb begin
        stable_next = stable;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST)
                    stable_next[i] = ~stable[i];
                else
                    cnt_next[i] = cnt[i] + 1'b1;
            end
        end
    end

    assign clr_rise  = (writeEnable && sel == 2'd1) ? writeData[WIDTH-1:0] : '0;
    assign clr_fall  = (writeEnable && sel == 2'd2) ? writeData[WIDTH-1:0] : '0;
    // Set terms are OR'd after the clear so a coincident edge wins over W1C.
    assign rise_next = (rise & ~clr_rise) | (stable_next & ~stable);
    assign fall_next = (fall & ~clr_fall) | (~stable_next & stable);

`ifdef SWITCH_IRQ_EN
    logic [WIDTH-1:0] mask, mask_next;
    logic             irq_next;

    assign mask_next = (writeEnable && sel == 2'd3) ? writeData[WIDTH-1:0] : mask;
    assign irq_next  = |((rise_next | fall_next) & mask_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= '0;
            irq  <= 1'b0;
        end else begin
            mask <= mask_next;
            irq  <= irq_next;
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        reg_val = '0;
        case (sel)
            2'd0: reg_val = 32'(stable);
            2'd1: reg_val = 32'(rise);
            2'd2: reg_val = 32'(fall);
`ifdef SWITCH_IRQ_EN
            2'd3: reg_val = 32'(mask);
`else
            2'd3: reg_val = '0;
`endif
            default: reg_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            rise     <= '0;
            fall     <= '0;
            readData <= '0;
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= '0;
        end else begin
            sync1  <= switches;
            sync2  <= sync1;
            stable <= stable_next;
            rise   <= rise_next;
            fall   <= fall_next;
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= cnt_next[i];
            if (readEnable)
                readData <= reg_val;
        end
    end
endmodule
